if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 101 ++++++++++
 tb/tb_if_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register and fetch counter.
// Optional backward-branch static prediction under IF_STATIC_PREDICT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_PC,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Rdata,
  output logic        IfId_Valid,
  output logic [31:0] IfId_Instr,
  output logic [31:0] IfId_PC4,
  output logic        IfId_PredTaken,
  output logic [31:0] Fetch_Count
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] pc_next;
  logic [31:0] word_idx;
  logic        in_range;
  logic        squash;
  logic        take;
  logic        pred;
  logic [31:0] pred_target;

  assign Imem_Addr = pc;
  assign pc4       = pc + 32'd4;
  assign word_idx  = {2'b00, pc[31:2]};
  assign in_range  = word_idx < 32'(IMEM_WORDS);
  assign squash    = Redirect_Valid | Flush;
  assign take      = ~squash & ~Stall;

`ifdef IF_STATIC_PREDICT_EN
  logic is_br;
  logic [31:0] br_off;

  assign is_br = (Imem_Rdata[31:26] == 6'b000100)
              || (Imem_Rdata[31:26] == 6'b000101);
  assign pred  = is_br & Imem_Rdata[15] & in_range
               & ~Stall & ~Redirect_Valid;
  assign br_off = {{14{Imem_Rdata[15]}},
                   Imem_Rdata[15:0], 2'b00};
  assign pred_target = pc4 + br_off;
`else
  assign pred        = 1'b0;
  assign pred_target = pc4;
`endif

  // Next-PC select: redirect, then stall hold, then prediction, else PC+4.
  always_comb begin
    pc_next = pc4;
    if (Redirect_Valid)
      pc_next = Redirect_PC;
    else if (Stall)
      pc_next = pc;
    else if (pred)
      pc_next = pred_target;
  end

  // PC register; every load is forced word-aligned.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      pc <= RESET_PC;
    else
      pc <= pc_next & 32'hFFFF_FFFC;
  end

  // IF/ID register: squash to a bubble, hold on stall, else capture.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      IfId_Valid     <= 1'b0;
      IfId_Instr     <= 32'h0;
      IfId_PC4       <= 32'h0;
      IfId_PredTaken <= 1'b0;
    end else if (squash) begin
      IfId_Valid     <= 1'b0;
      IfId_Instr     <= 32'h0;
      IfId_PredTaken <= 1'b0;
    end else if (!Stall) begin
      IfId_Valid     <= in_range;
      IfId_Instr     <= in_range ? Imem_Rdata : 32'h0;
      IfId_PC4       <= pc4;
      IfId_PredTaken <= pred;
    end
  end

  // Count every edge that captures a valid instruction.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      Fetch_Count <= 32'h0;
    else if (take && in_range)
      Fetch_Count <= Fetch_Count + 32'd1;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small instruction memory model.
// Expected values follow the build: IF_STATIC_PREDICT_EN selects them.
module tb_if_stage;

  logic        Clock;
  logic        Reset_n;
  logic        Stall;
  logic        Flush;
  logic        Redirect_Valid;
  logic [31:0] Redirect_PC;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Rdata;
  logic        IfId_Valid;
  logic [31:0] IfId_Instr;
  logic [31:0] IfId_PC4;
  logic        IfId_PredTaken;
  logic [31:0] Fetch_Count;

  logic [31:0] imem [256];
  int checks;
  int failures;

  if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .Stall(Stall),
    .Flush(Flush),
    .Redirect_Valid(Redirect_Valid),
    .Redirect_PC(Redirect_PC),
    .Imem_Addr(Imem_Addr),
    .Imem_Rdata(Imem_Rdata),
    .IfId_Valid(IfId_Valid),
    .IfId_Instr(IfId_Instr),
    .IfId_PC4(IfId_PC4),
    .IfId_PredTaken(IfId_PredTaken),
    .Fetch_Count(Fetch_Count)
  );

  assign Imem_Rdata = (Imem_Addr[31:10] == 22'h0)
                    ? imem[Imem_Addr[9:2]] : 32'hDEAD_BEEF;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".addr"}, Imem_Addr, 32'h0);
    chk({tag, ".valid"}, 32'(IfId_Valid), 32'h0);
    chk({tag, ".instr"}, IfId_Instr, 32'h0);
    chk({tag, ".pc4"}, IfId_PC4, 32'h0);
    chk({tag, ".pred"}, 32'(IfId_PredTaken), 32'h0);
    chk({tag, ".count"}, Fetch_Count, 32'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++)
      imem[i] = 32'hA000_0000 | 32'(i);
    imem[4] = 32'h1000_FFFE;
    Reset_n = 1'b0;
    Stall = 1'b0;
    Flush = 1'b0;
    Redirect_Valid = 1'b0;
    Redirect_PC = 32'h0;
    repeat (2) @(negedge Clock);
    chk_reset("rst");

    Reset_n = 1'b1;
    chk("run.a0", Imem_Addr, 32'h0);
    step();
    chk("run.a4", Imem_Addr, 32'h4);
    chk("run.p4", IfId_PC4, 32'h4);
    chk("run.i0", IfId_Instr, 32'hA000_0000);
    step();
    chk("run.a8", Imem_Addr, 32'h8);
    chk("run.p8", IfId_PC4, 32'h8);
    step();
    chk("run.a12", Imem_Addr, 32'hC);
    chk("run.p12", IfId_PC4, 32'hC);
    chk("run.cnt", Fetch_Count, 32'd3);

    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    step();
    step();
    chk("pre.addr", Imem_Addr, 32'h8);
    Stall = 1'b1;
    step();
    step();
    chk("stl.addr", Imem_Addr, 32'h8);
    chk("stl.instr", IfId_Instr, 32'hA000_0001);
    chk("stl.pc4", IfId_PC4, 32'h8);
    chk("stl.cnt", Fetch_Count, 32'd2);

    Redirect_Valid = 1'b1;
    Redirect_PC = 32'h42;
    step();
    chk("rdr.addr", Imem_Addr, 32'h40);
    chk("rdr.valid", 32'(IfId_Valid), 32'h0);
    chk("rdr.instr", IfId_Instr, 32'h0);
    chk("rdr.pc4", IfId_PC4, 32'h8);
    Redirect_Valid = 1'b0;
    Stall = 1'b0;
    step();
    chk("rdr.nvalid", 32'(IfId_Valid), 32'h1);
    chk("rdr.ninstr", IfId_Instr, 32'hA000_0010);
    chk("rdr.npc4", IfId_PC4, 32'h44);
    chk("rdr.cnt", Fetch_Count, 32'd3);

    Redirect_Valid = 1'b1;
    Redirect_PC = 32'h400;
    step();
    chk("oor.addr", Imem_Addr, 32'h400);
    Redirect_Valid = 1'b0;
    step();
    chk("oor.valid", 32'(IfId_Valid), 32'h0);
    chk("oor.instr", IfId_Instr, 32'h0);
    chk("oor.cnt", Fetch_Count, 32'd3);
    chk("oor.next", Imem_Addr, 32'h404);

    Redirect_Valid = 1'b1;
    Redirect_PC = 32'h10;
    step();
    chk("br.addr", Imem_Addr, 32'h10);
    Redirect_Valid = 1'b0;
    step();
    chk("br.instr", IfId_Instr, 32'h1000_FFFE);
    chk("br.pc4", IfId_PC4, 32'h14);
    chk("br.cnt", Fetch_Count, 32'd4);
`ifdef IF_STATIC_PREDICT_EN
    chk("br.next", Imem_Addr, 32'hC);
    chk("br.pred", 32'(IfId_PredTaken), 32'h1);
`else
    chk("br.next", Imem_Addr, 32'h14);
    chk("br.pred", 32'(IfId_PredTaken), 32'h0);
`endif

    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("fl.valid", 32'(IfId_Valid), 32'h0);
    chk("fl.instr", IfId_Instr, 32'h0);
    chk("fl.pred", 32'(IfId_PredTaken), 32'h0);
    chk("fl.pc4", IfId_PC4, 32'h14);
    chk("fl.cnt", Fetch_Count, 32'd4);
`ifdef IF_STATIC_PREDICT_EN
    chk("fl.addr", Imem_Addr, 32'h10);
`else
    chk("fl.addr", Imem_Addr, 32'h18);
`endif
    step();
    chk("fl.rvalid", 32'(IfId_Valid), 32'h1);

    Redirect_Valid = 1'b1;
    Redirect_PC = 32'h80;
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset("arst");
    @(negedge Clock);
    chk_reset("arst.hold");
    Redirect_Valid = 1'b0;
    Reset_n = 1'b1;
    step();
    chk("arst.addr", Imem_Addr, 32'h4);
    chk("arst.cnt", Fetch_Count, 32'd1);

    Redirect_Valid = 1'b1;
    Redirect_PC = 32'hFFFF_FFFF;
    step();
    chk("wrap.addr", Imem_Addr, 32'hFFFF_FFFC);
    Redirect_Valid = 1'b0;
    step();
    chk("wrap.next", Imem_Addr, 32'h0);
    chk("wrap.pc4", IfId_PC4, 32'h0);
    chk("wrap.valid", 32'(IfId_Valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
